// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and sigma functions, used by the message schedule and the round core.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 64;
  localparam int WINDOW    = 16;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/schedule_word.sv
// Combinational schedule recurrence: W[t+16] from the four taps of the 16-word window.
module schedule_word (
  input  logic [31:0] w_t,
  input  logic [31:0] w_t1,
  input  logic [31:0] w_t9,
  input  logic [31:0] w_t14,
  output logic [31:0] w_next
);
  import sha256_pkg::*;

  // Carries out of bit 31 are dropped by the 32-bit result width.
  assign w_next = small_sigma1(w_t14) + w_t9 + small_sigma0(w_t1) + w_t;

endmodule

// File: rtl/message_expander.sv
// SHA-256 message schedule: loads one 512-bit block and streams W0..W63 over a
// valid/ready handshake, generating W16..W63 in place from a 16-word sliding window.
module message_expander #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [511:0]      block_in,
  output logic              in_ready,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [5:0]        w_index,
  output logic              w_last
);
  import sha256_pkg::*;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  word_t      window_q [WINDOW];
  word_t      window_d [WINDOW];
  word_t      next_word;

  schedule_word u_schedule_word (
    .w_t    (window_q[0]),
    .w_t1   (window_q[1]),
    .w_t9   (window_q[9]),
    .w_t14  (window_q[14]),
    .w_next (next_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      window_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      window_q <= window_d;
    end
  end

  // The words computed past idx 47 are never emitted; writing them anyway keeps the shift uniform.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < WINDOW; i++) begin
            window_d[i] = block_in[(511 - 32*i) -: 32];
          end
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (w_ready) begin
          for (int i = 0; i < WINDOW - 1; i++) begin
            window_d[i] = window_q[i+1];
          end
          window_d[WINDOW-1] = next_word;
          idx_d = idx_q + 6'd1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come only from registers, so w_ready may safely depend on w_valid downstream.
  assign in_ready = (state_q == IDLE);
  assign w_valid  = (state_q == STREAM);
  assign w_word   = window_q[0];
  assign w_index  = idx_q;
  assign w_last   = (state_q == STREAM) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_message_expander.sv
// Directed and randomized bench for message_expander with a reference-model scoreboard.
module tb_message_expander;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  index;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic         in_ready;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         w_last;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  message_expander dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .in_ready (in_ready),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_index  (w_index),
    .w_last   (w_last)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-entry reference schedule in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  function automatic void push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = b[(511 - 32*i) -: 32];
    for (int t = 16; t < 64; t++) w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.word  = w[t];
      e.index = 6'(t);
      e.last  = (t == 63);
      exp_q.push_back(e);
    end
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compares the DUT against the scoreboard front every cycle, before the active edge.
  task automatic observe();
    exp_t e;
    if (rst) return;
    check_output("w_valid", 64'(w_valid), 64'(exp_q.size() > 0));
    check_output("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
    if (w_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      check_output("w_word", 64'(w_word), 64'(e.word));
      check_output("w_index", 64'(w_index), 64'(e.index));
      check_output("w_last", 64'(w_last), 64'(e.last));
      if (w_ready) void'(exp_q.pop_front());
    end
    if (start && in_ready) push_block(block_in);
  endtask

  // Drives one cycle starting from a falling edge and returns at the next falling edge.
  task automatic apply_stimulus(input logic s, input logic r, input logic [511:0] b);
    start    = s;
    w_ready  = r;
    block_in = b;
    #1;
    observe();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int ready_pct, input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      apply_stimulus(1'b0, ($urandom_range(99) < ready_pct), {16{$urandom()}});
      n++;
    end
    check_output("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; block_in = '0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_w_valid", 64'(w_valid), 64'd0);
    check_output("rst_w_word", 64'(w_word), 64'd0);
    check_output("rst_w_index", 64'(w_index), 64'd0);
    check_output("rst_w_last", 64'(w_last), 64'd0);
    rst = 1'b0;

    // "abc" block at full throughput, with spot checks on known schedule words.
    apply_stimulus(1'b1, 1'b1, ABC_BLOCK);
    for (int k = 0; k < 64; k++) begin
      if (k == 0)  check_output("abc_w0", 64'(w_word), 64'h61626380);
      if (k == 15) check_output("abc_w15", 64'(w_word), 64'h00000018);
      if (k == 16) check_output("abc_w16", 64'(w_word), 64'h61626380);
      if (k == 17) check_output("abc_w17", 64'(w_word), 64'h000F0000);
      apply_stimulus(1'b0, 1'b1, '0);
    end
    check_output("abc_done", 64'(exp_q.size()), 64'd0);

    // Same block under random backpressure.
    apply_stimulus(1'b1, 1'b0, ABC_BLOCK);
    drain(50, 1000);

    // Mid-stream start with a different block must be ignored.
    apply_stimulus(1'b1, 1'b1, ABC_BLOCK);
    for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 1'b1, '0);
    apply_stimulus(1'b1, 1'b1, {16{32'hDEADBEEF}});
    apply_stimulus(1'b1, 1'b0, {16{32'h12345678}});
    drain(100, 200);

    // Back-to-back: start in the first idle cycle after the W63 handshake.
    apply_stimulus(1'b1, 1'b1, rand_block());
    drain(100, 200);
    check_output("b2b_in_ready", 64'(in_ready), 64'd1);
    apply_stimulus(1'b1, 1'b1, {16{32'hFFFFFFFF}});
    check_output("b2b_latency", 64'(w_valid), 64'd1);
    drain(100, 200);

    // Reset while streaming at idx 30 abandons the block.
    apply_stimulus(1'b1, 1'b1, ABC_BLOCK);
    for (int k = 0; k < 30; k++) apply_stimulus(1'b0, 1'b1, '0);
    check_output("pre_rst_index", 64'(w_index), 64'd30);
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b1, '0);
    rst = 1'b0;
    exp_q.delete();
    check_output("post_rst_valid", 64'(w_valid), 64'd0);
    check_output("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_output("post_rst_index", 64'(w_index), 64'd0);
    apply_stimulus(1'b1, 1'b1, rand_block());
    drain(100, 200);

    // Random blocks, including the all-ones wrap case, under random backpressure.
    apply_stimulus(1'b1, 1'b0, {16{32'hFFFFFFFF}});
    drain(70, 1000);
    for (int n = 0; n < 150; n++) begin
      apply_stimulus(1'b1, ($urandom_range(99) < 70), rand_block());
      drain(70, 1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
